// File: rtl/if_signal_gen.sv
// GPS L1 C/A IF sample source: emits the 2-bit sign/magnitude stream a
// tracking channel consumes, with programmable PRN, whole-chip code delay,
// carrier/code NCO words and a circular 32-bit navigation word.
module if_signal_gen #(
    parameter int CARR_ACC_W = 29,
    parameter int CODE_ACC_W = 29,
    parameter int MS_PER_BIT = 20
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [27:0] carr_fc,
    input  logic [26:0] code_fc,
    input  logic [9:0]  prn_key,
    input  logic [9:0]  code_delay,
    input  logic [31:0] nav_word,
    output logic        if_sign,
    output logic        if_mag,
    output logic        sample_valid,
    output logic        code_epoch,
    output logic        data_bit,
    output logic        busy
);

    localparam int MS_W       = (MS_PER_BIT > 1) ? $clog2(MS_PER_BIT) : 1;
    localparam int CODE_SUM_W = CODE_ACC_W + 1;

    typedef enum logic [1:0] {IDLE, ADVANCE, RUN} state_t;

    // G1/G2 registers hold stage n at bit (10 - n): bit 0 is stage 10 (the
    // output tap) and the register shifts towards bit 0.
    function automatic logic [9:0] g1_shift(input logic [9:0] g);
        return {g[7] ^ g[0], g[9:1]};                          // stages 3, 10
    endfunction

    function automatic logic [9:0] g2_shift(input logic [9:0] g);
        return {g[8] ^ g[7] ^ g[4] ^ g[2] ^ g[1] ^ g[0], g[9:1]}; // 2,3,6,8,9,10
    endfunction

    state_t                state_q, state_d;
    logic [CARR_ACC_W-1:0] carr_ph_q;
    logic [CODE_ACC_W-1:0] code_ph_q;
    logic [CODE_SUM_W-1:0] code_sum;
    logic [27:0]           carr_fc_q;
    logic [26:0]           code_fc_q;
    logic [9:0]            key_q;
    logic [31:0]           nav_q;
    logic [9:0]            g1_q, g2_q;
    logic [9:0]            chip_cnt_q;
    logic [9:0]            adv_q;
    logic [9:0]            adv_load;
    logic [MS_W-1:0]       ms_cnt_q;
    logic [4:0]            bit_idx_q;
    logic                  epoch_pend_q;
    logic                  chip;
    logic                  nav_bit;
    logic                  emit;
    logic                  valid_d, sign_d, mag_d, epoch_d, data_d;

    assign adv_load = (code_delay == 10'd0) ? 10'd0 : 10'd1023 - code_delay;
    assign code_sum = {1'b0, code_ph_q} + CODE_SUM_W'(code_fc_q);
    assign chip     = g1_q[0] ^ g2_q[0];
    assign nav_bit  = nav_q[bit_idx_q];
    assign busy     = (state_q == ADVANCE);

    // State register; reset is synchronous to clk.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state: start overrides everything, ADVANCE ends on its last chip.
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        if (start)
            state_d = (adv_load == 10'd0) ? RUN : ADVANCE;
        else if (state_q == ADVANCE && adv_q == 10'd1)
            state_d = RUN;
    end

    // Sample for this cycle, taken from phase/chip state before its update.
    always_comb begin
        emit    = (state_q == RUN) && !start;
        valid_d = emit;
        sign_d  = emit & (chip ^ nav_bit ^ carr_ph_q[CARR_ACC_W-1]);
        mag_d   = emit & (carr_ph_q[CARR_ACC_W-2] ^ carr_ph_q[CARR_ACC_W-3]);
        epoch_d = emit & epoch_pend_q;
        data_d  = emit & nav_bit;
    end

    // Registered outputs; all zero whenever no sample is emitted.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sample_valid <= 1'b0;
            if_sign      <= 1'b0;
            if_mag       <= 1'b0;
            code_epoch   <= 1'b0;
            data_bit     <= 1'b0;
        end else begin
            sample_valid <= valid_d;
            if_sign      <= sign_d;
            if_mag       <= mag_d;
            code_epoch   <= epoch_d;
            data_bit     <= data_d;
        end
    end

    // Config latch, pre-advance of the code and NCO/chip/bit bookkeeping.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            carr_ph_q    <= '0;
            code_ph_q    <= '0;
            carr_fc_q    <= '0;
            code_fc_q    <= '0;
            key_q        <= '0;
            nav_q        <= '0;
            g1_q         <= '0;
            g2_q         <= '0;
            chip_cnt_q   <= '0;
            adv_q        <= '0;
            ms_cnt_q     <= '0;
            bit_idx_q    <= '0;
            epoch_pend_q <= 1'b0;
        end else if (start) begin
            carr_fc_q    <= carr_fc;
            code_fc_q    <= code_fc;
            key_q        <= prn_key;
            nav_q        <= nav_word;
            carr_ph_q    <= '0;
            code_ph_q    <= '0;
            g1_q         <= 10'h3FF;
            g2_q         <= prn_key;
            chip_cnt_q   <= '0;
            adv_q        <= adv_load;
            ms_cnt_q     <= '0;
            bit_idx_q    <= 5'd31;
            // With no delay the very first RUN sample already sits on chip 0.
            epoch_pend_q <= (adv_load == 10'd0);
        end else begin
            case (state_q)
                ADVANCE: begin
                    g1_q       <= g1_shift(g1_q);
                    g2_q       <= g2_shift(g2_q);
                    chip_cnt_q <= chip_cnt_q + 10'd1;
                    adv_q      <= adv_q - 10'd1;
                end
                RUN: begin
                    carr_ph_q    <= carr_ph_q + CARR_ACC_W'(carr_fc_q);
                    code_ph_q    <= code_sum[CODE_ACC_W-1:0];
                    epoch_pend_q <= 1'b0;
                    if (code_sum[CODE_ACC_W]) begin
                        if (chip_cnt_q == 10'd1022) begin
                            g1_q         <= 10'h3FF;
                            g2_q         <= key_q;
                            chip_cnt_q   <= '0;
                            epoch_pend_q <= 1'b1;
                            if (ms_cnt_q == MS_W'(MS_PER_BIT - 1)) begin
                                ms_cnt_q  <= '0;
                                bit_idx_q <= bit_idx_q - 5'd1;
                            end else begin
                                ms_cnt_q <= ms_cnt_q + 1'b1;
                            end
                        end else begin
                            g1_q       <= g1_shift(g1_q);
                            g2_q       <= g2_shift(g2_q);
                            chip_cnt_q <= chip_cnt_q + 10'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_signal_gen.sv
// Directed, table-driven bench for if_signal_gen. Observed outputs are packed
// as {busy, sample_valid, code_epoch, data_bit, if_sign, if_mag}. The DUT is
// built with MS_PER_BIT = 2 so data-bit transitions fit a short run.
module tb_if_signal_gen;

    typedef struct {
        logic [27:0] carr;
        logic [26:0] code;
        logic [9:0]  delay;
        logic [31:0] nav;
    } cfg_t;

    typedef struct {
        string       name;
        logic        restart;
        cfg_t        cfg;
        int          n;
        logic [5:0]  exp;
        logic [5:0]  mask;
    } vec_t;

    localparam logic [5:0] ALL     = 6'b111111;
    localparam logic [5:0] NO_SIGN = 6'b111101;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [27:0] carr_fc;
    logic [26:0] code_fc;
    logic [9:0]  prn_key;
    logic [9:0]  code_delay;
    logic [31:0] nav_word;
    logic        if_sign, if_mag, sample_valid, code_epoch, data_bit, busy;
    logic [5:0]  obs;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cur      = 0;
    vec_t vecs[$];
    cfg_t cur_cfg;
    logic pend_restart;

    if_signal_gen #(.MS_PER_BIT(2)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .carr_fc     (carr_fc),
        .code_fc     (code_fc),
        .prn_key     (prn_key),
        .code_delay  (code_delay),
        .nav_word    (nav_word),
        .if_sign     (if_sign),
        .if_mag      (if_mag),
        .sample_valid(sample_valid),
        .code_epoch  (code_epoch),
        .data_bit    (data_bit),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    assign obs = {busy, sample_valid, code_epoch, data_bit, if_sign, if_mag};

    task automatic check(input string name, input logic [5:0] act,
                         input logic [5:0] exp, input logic [5:0] mask);
        n_checks++;
        if ((act & mask) !== (exp & mask)) begin
            n_fail++;
            $display("FAIL %s: got %b required %b (mask %b, busy/valid/epoch/data/sign/mag)",
                     name, act, exp, mask);
        end
    endtask

    // Pulse start so that it is sampled at edge k; returns at the falling
    // edge after k with cur = 0.
    task automatic do_start(input cfg_t c);
        @(negedge clk);
        carr_fc    = c.carr;
        code_fc    = c.code;
        code_delay = c.delay;
        nav_word   = c.nav;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cur   = 0;
    endtask

    task automatic step_to(input int n);
        while (cur < n) begin
            @(negedge clk);
            cur++;
        end
    endtask

    function automatic void group(input cfg_t c);
        cur_cfg      = c;
        pend_restart = 1'b1;
    endfunction

    function automatic void row(input string name, input int n,
                                input logic [5:0] exp, input logic [5:0] mask);
        vecs.push_back('{name: name, restart: pend_restart, cfg: cur_cfg,
                         n: n, exp: exp, mask: mask});
        pend_restart = 1'b0;
    endfunction

    initial begin
        cfg_t c;
        rstn       = 1'b0;
        start      = 1'b0;
        carr_fc    = '0;
        code_fc    = '0;
        prn_key    = 10'h3EC;
        code_delay = '0;
        nav_word   = '0;

        // PRN 1, delay 0, one chip per 16 samples: chip starts at n = 16j+1
        // read 1100100000; epoch on the first sample.
        group('{carr: 28'h0, code: 27'h200_0000, delay: 10'd0, nav: 32'h0});
        row("prn_start_edge", 0,   6'b000000, ALL);
        row("prn_chip0",      1,   6'b011010, ALL);
        row("prn_chip0_b",    2,   6'b010010, ALL);
        row("prn_chip0_end",  16,  6'b010010, ALL);
        row("prn_chip1",      17,  6'b010010, ALL);
        row("prn_chip2",      33,  6'b010000, ALL);
        row("prn_chip3",      49,  6'b010000, ALL);
        row("prn_chip4",      65,  6'b010010, ALL);
        row("prn_chip5",      81,  6'b010000, ALL);
        row("prn_chip6",      97,  6'b010000, ALL);
        row("prn_chip7",      113, 6'b010000, ALL);
        row("prn_chip8",      129, 6'b010000, ALL);
        row("prn_chip9",      145, 6'b010000, ALL);

        // Quarter-rate carrier, frozen code (chip stays 1): phase steps of 90
        // degrees give mag 0,1,0,1 and sign = 1 ^ phase msb = 1,1,0,0.
        group('{carr: 28'h800_0000, code: 27'h0, delay: 10'd0, nav: 32'h0});
        row("carr_s1", 1, 6'b011010, ALL);
        row("carr_s2", 2, 6'b010011, ALL);
        row("carr_s3", 3, 6'b010000, ALL);
        row("carr_s4", 4, 6'b010001, ALL);
        row("carr_s5", 5, 6'b010010, ALL);
        row("carr_s6", 6, 6'b010011, ALL);

        // Delay 4: 1019 advance cycles, first sample at 1020, epoch 64 later.
        group('{carr: 28'h0, code: 27'h200_0000, delay: 10'd4, nav: 32'h0});
        row("dly_busy_first",  0,    6'b100000, ALL);
        row("dly_busy_last",   1018, 6'b100000, ALL);
        row("dly_no_sample",   1019, 6'b000000, ALL);
        row("dly_first_valid", 1020, 6'b010000, NO_SIGN);
        row("dly_pre_epoch",   1083, 6'b010000, NO_SIGN);
        row("dly_epoch",       1084, 6'b011010, ALL);

        // nav 0xAAAA_AAAA: bit 31 = 1 for two epochs, bit 30 = 0, bit 29 = 1;
        // epochs every 16368 samples, sign inverted by the data bit.
        group('{carr: 28'h0, code: 27'h200_0000, delay: 10'd0, nav: 32'hAAAA_AAAA});
        row("nav_ep1",      1,     6'b011100, ALL);
        row("nav_ep1_end",  16368, 6'b010100, NO_SIGN);
        row("nav_ep2",      16369, 6'b011100, ALL);
        row("nav_ep2_end",  32736, 6'b010100, NO_SIGN);
        row("nav_ep3_flip", 32737, 6'b011010, ALL);
        row("nav_ep4_end",  65472, 6'b010000, NO_SIGN);
        row("nav_ep5_flip", 65473, 6'b011100, ALL);

        repeat (3) @(negedge clk);
        check("reset_state", obs, 6'b000000, ALL);
        rstn = 1'b1;
        @(negedge clk);
        check("idle_no_start", obs, 6'b000000, ALL);

        foreach (vecs[i]) begin
            if (vecs[i].restart) do_start(vecs[i].cfg);
            step_to(vecs[i].n);
            check(vecs[i].name, obs, vecs[i].exp, vecs[i].mask);
        end

        // Reset held for 5 cycles mid-RUN, then idle until the next start.
        c = '{carr: 28'h800_0000, code: 27'h0, delay: 10'd0, nav: 32'h0};
        do_start(c);
        step_to(2);
        check("run_before_reset", obs, 6'b010011, ALL);
        rstn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("reset_mid_run", obs, 6'b000000, ALL);
        end
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_after_reset", obs, 6'b000000, ALL);
        end
        do_start(c);
        step_to(1);
        check("restart_after_reset", obs, 6'b011010, ALL);

        // Reset during ADVANCE drops busy on the next edge.
        c = '{carr: 28'h0, code: 27'h200_0000, delay: 10'd4, nav: 32'h0};
        do_start(c);
        step_to(10);
        check("adv_busy", obs, 6'b100000, ALL);
        rstn = 1'b0;
        @(negedge clk);
        check("reset_mid_adv", obs, 6'b000000, ALL);
        rstn = 1'b1;

        // Restart during ADVANCE with delay 0 goes straight to RUN.
        do_start(c);
        step_to(100);
        c.delay = 10'd0;
        do_start(c);
        check("restart_in_adv_edge", obs, 6'b000000, ALL);
        step_to(1);
        check("restart_in_adv_first", obs, 6'b011010, ALL);

        // Chip wrap at edge k+8184 (8 samples/chip) coincides with a start:
        // no epoch, and the new delay-4 run begins its advance.
        c = '{carr: 28'h0, code: 27'h400_0000, delay: 10'd0, nav: 32'h0};
        do_start(c);
        step_to(8182);
        check("wrap_pre_restart", obs, 6'b010000, 6'b011000);
        c.delay = 10'd4;
        do_start(c);
        check("wrap_start_no_epoch", obs, 6'b100000, ALL);
        step_to(1);
        check("wrap_start_advancing", obs, 6'b100000, ALL);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
